// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-side request/response and bridge-side refill signals of the instruction cache.
interface icache_direct_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic        mem_burst_ok;
  modport master (
    output cpu_req, cpu_addr, flush, mem_rdata, mem_addr_ok, mem_data_ok, mem_burst_ok,
    input  cpu_ready, cpu_rvalid, cpu_rdata, mem_en, mem_wen, mem_addr, mem_wdata
  );
  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rdata, mem_addr_ok, mem_data_ok, mem_burst_ok,
    output cpu_ready, cpu_rvalid, cpu_rdata, mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache; 1-cycle hits, misses refill one line
// as a single burst through the bridge en/addr_ok/data_ok/burst_ok handshake.
module icache_direct #(
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 64
) (
  input logic            clk,
  input logic            rstn,
  icache_direct_if.slave bus
);
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = 32 - OFF_W - INDEX_W;
  localparam int WORDS   = LINE_BYTES / 4;
  localparam int CNT_W   = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL   = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [31:0]        r_addr;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag     [SETS];
  logic [31:0]        r_data    [SETS][WORDS];
  logic [31:0]        r_linebuf [WORDS];
  logic [CNT_W-1:0]   r_cnt;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [CNT_W-1:0]   w_woff;
  logic               w_hit;
  logic               w_resp;
  logic               w_beat;
  assign w_idx  = r_addr[OFF_W +: INDEX_W];
  assign w_tag  = r_addr[31 -: TAG_W];
  assign w_woff = CNT_W'(r_addr[OFF_W-1:0] >> 2);
  assign w_resp = r_state == S_RESP;
  assign w_beat = r_state == S_REFILL && bus.mem_data_ok;
  // Lookup reads the valid bits as they stand, so a same-cycle flush only affects later lookups.
  assign w_hit  = r_state == S_LOOKUP && r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign bus.cpu_ready  = r_state == S_IDLE || w_hit;
  assign bus.cpu_rvalid = w_hit || w_resp;
  assign bus.cpu_rdata  = w_hit ? r_data[w_idx][w_woff] : w_resp ? r_linebuf[w_woff] : '0;
  assign bus.mem_en     = r_state == S_MISS_REQ || r_state == S_REFILL;
  assign bus.mem_addr   = bus.mem_en ? {r_addr[31:OFF_W], OFF_W'(0)} : '0;
  assign bus.mem_wen    = 1'b0;
  assign bus.mem_wdata  = '0;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:     w_next = bus.cpu_req ? S_LOOKUP : S_IDLE;
      S_LOOKUP:   w_next = !w_hit ? S_MISS_REQ : bus.cpu_req ? S_LOOKUP : S_IDLE;
      S_MISS_REQ: w_next = bus.mem_addr_ok ? S_REFILL : S_MISS_REQ;
      S_REFILL:   w_next = bus.mem_burst_ok ? S_RESP : S_REFILL;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (bus.cpu_req && bus.cpu_ready) r_addr <= bus.cpu_addr;
      // flush beats the fill of the line completing in RESP
      r_valid <= bus.flush ? '0 : r_valid | (w_resp ? SETS'(1) << w_idx : '0);
      r_cnt   <= w_resp ? '0 : w_beat ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_beat) r_linebuf[r_cnt] <= bus.mem_rdata;
    if (w_resp) begin
      r_tag[w_idx] <= w_tag;
      for (int i = 0; i < WORDS; i++) r_data[w_idx][i] <= r_linebuf[i];
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: randomized fetch traffic against a set/tag/data reference model, plus a
// bridge model delivering 4-beat bursts with random gaps; directed flush and reset scenarios.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  icache_direct_if bus();
  icache_direct dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  logic [7:0]  gen = 8'd0;
  logic        m_flush = 1'b0;
  logic        b_flush = 1'b0;
  assign bus.flush = m_flush | b_flush;
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [7:0] g);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ {4{g}} ^ 32'h0000_1234;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask
  int          b_phase = 0;
  int          b_wait = 0;
  int          b_beat = 0;
  int          b_low = 99;
  bit          b_flush_beat1 = 1'b0;
  logic [31:0] b_addr = '0;
  initial begin
    bus.mem_rdata = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_burst_ok = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_burst_ok = 1'b0;
      b_flush = 1'b0;
      if (!rstn) begin
        b_phase = 0;
        b_low = 99;
      end else if (b_phase == 0) begin
        if (bus.mem_en) begin
          chk("en_gap", 32'(b_low >= 3), 32'd1);
          b_addr = bus.mem_addr;
          chk("align", {28'd0, b_addr[3:0]}, 32'd0);
          chk("wen", {31'd0, bus.mem_wen}, 32'd0);
          chk("wdata", bus.mem_wdata, 32'd0);
          b_wait = $urandom_range(0, 2);
          b_phase = 1;
          b_beat = 0;
        end else b_low++;
      end
      if (rstn && b_phase == 1) begin
        if (b_wait > 0) b_wait--;
        else begin
          bus.mem_addr_ok = 1'b1;
          b_phase = 2;
          b_wait = $urandom_range(0, 2);
        end
      end else if (rstn && b_phase == 2) begin
        chk("addr_hold", bus.mem_addr, b_addr);
        if (b_wait > 0) b_wait--;
        else begin
          bus.mem_data_ok = 1'b1;
          bus.mem_rdata = mem_word(b_addr + 32'(b_beat * 4), gen);
          bus.mem_burst_ok = b_beat == 3;
          b_flush = b_flush_beat1 && b_beat == 1;
          b_beat++;
          b_wait = $urandom_range(0, 2);
          if (b_beat == 4) begin
            b_phase = 0;
            b_low = 0;
          end
        end
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (!bus.cpu_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
  endtask
  // fmode: 0 plain, 1 flush during refill beat 1, 2 flush in the response cycle of a miss
  task automatic issue(input logic [31:0] a, input int fmode);
    bit          hit;
    bit          saw;
    int          n;
    int          s;
    logic [31:0] exp;
    s = int'(a[9:4]);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    wait_ready();
    hit = m_valid[s] && m_tag[s] == a[31:10];
    if (hit) fmode = 0;
    b_flush_beat1 = fmode == 1;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_addr = $urandom;
    if (!hit) begin
      if (fmode == 1) model_clear();
      m_valid[s] = 1'b1;
      m_tag[s] = a[31:10];
      for (int k = 0; k < 4; k++) m_data[s][k] = mem_word({a[31:4], 4'h0} + 32'(k * 4), gen);
    end
    exp = m_data[s][a[3:2]];
    if (fmode == 2) model_clear();
    n = 0;
    saw = 1'b0;
    while (!bus.cpu_rvalid && n < 100) begin
      if (bus.mem_en && !saw) begin
        chk("mem_addr", bus.mem_addr, {a[31:4], 4'h0});
        saw = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rvalid_timeout", 32'd0, 32'd1);
    chk("miss", {31'd0, saw}, {31'd0, !hit});
    chk("rdata", bus.cpu_rdata, exp);
    chk("ready_at_resp", {31'd0, bus.cpu_ready}, {31'd0, hit});
    if (hit) chk("hit_latency", 32'(n), 32'd0);
    else chk("en_in_resp", {31'd0, bus.mem_en}, 32'd0);
    if (fmode == 2) begin
      m_flush = 1'b1;
      @(negedge clk);
      m_flush = 1'b0;
    end
    b_flush_beat1 = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.cpu_ready}, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd0);
    chk({tag, "_rdata"}, bus.cpu_rdata, 32'd0);
    chk({tag, "_en"}, {31'd0, bus.mem_en}, 32'd0);
    chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [31:0] l2 [3];
    logic [31:0] a;
    int n;
    int r;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    model_clear();
    #2;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(32'h0000_1004, 0);
    l2[0] = 32'h0000_1000;
    l2[1] = 32'h0000_100C;
    l2[2] = 32'h0000_1008;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      bus.cpu_req = 1'b1;
      bus.cpu_addr = l2[i];
      @(negedge clk);
      chk("b2b_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
      chk("b2b_rdata", bus.cpu_rdata, mem_word(l2[i], gen));
      chk("b2b_ready", {31'd0, bus.cpu_ready}, 32'd1);
      chk("b2b_en", {31'd0, bus.mem_en}, 32'd0);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("b2b_end", {31'd0, bus.cpu_rvalid}, 32'd0);
    issue(32'h0000_2004, 0);
    issue(32'h0000_1004, 0);
    issue(32'h0000_3000, 1);
    issue(32'h0000_3000, 0);
    issue(32'h0000_1000, 0);
    issue(32'h0000_4008, 2);
    issue(32'h0000_4008, 0);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_5004;
    wait_ready();
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!(b_phase == 2 && b_beat >= 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat2_timeout", 32'd0, 32'd1);
    #1 rstn = 1'b0;
    #1 chk_reset_outputs("midrst");
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    gen = gen + 8'd1;
    @(negedge clk);
    issue(32'h0000_5004, 0);
    issue(32'h0000_5000, 0);
    issue(32'h0000_5008, 0);
    issue(32'h0000_500C, 0);
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        @(negedge clk);
        m_flush = 1'b1;
        @(negedge clk);
        m_flush = 1'b0;
        model_clear();
      end else if (r < 7) gen = gen + 8'd1;
      else begin
        a = r < 12 ? $urandom : ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom & 32'hF);
        issue(a, r < 20 ? $urandom_range(0, 2) : 0);
      end
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
